uart_rx: RTL and testbench

UART receiver; receive-side counterpart to the team's UART transmitter, with matching frame format and parameters. Oversamples asynchronous serial input rx_i on clk_i and reassembles each frame into a parallel word. Presents each word with a 1-cycle valid pulse plus parity/framing status. Sits between the board UART pin and the host-side command/data path.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sampler.sv | 46 ++++
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state enum, default baud constant, parity helper.
// Also provides SAFE_CLOG2 for the UART files when the defs header has not
// already defined it.
`ifndef SAFE_CLOG2
`define SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package uart_pkg;

    // Receiver states; e_reset lasts one cycle after reset release.
    typedef enum logic [2:0] {
        e_reset,
        e_idle,
        e_start_bit,
        e_data_bits,
        e_parity_bit,
        e_stop_bit
    } rx_state_e;

    // 100 MHz clock / 9600 baud.
    localparam int unsigned default_clk_per_bit_lp = 10416;

    // Even-parity accumulator step: the running XOR of every bit seen so far.
    function automatic logic even_parity_step(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for uart_rx: 2-flop synchronizer, falling-edge detect and
// the sample value used by the receiver. Define UART_RX_MAJORITY_VOTE_EN to make
// each sample a 2-of-3 vote over the last three synchronized values.
module uart_rx_sampler (
    input  logic clk_i,
    input  logic reset_i,
    input  logic rx_i,
    output logic rx_s,
    output logic fall_edge,
    output logic voted_bit
);

    logic sync1, sync2, prev;

    // Synchronize the async line and keep one cycle of history for edge detect.
    // Everything resets high (idle line) so reset cannot look like a start.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rx_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rx_s      = sync2;
    assign fall_edge = prev & ~sync2;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic prev2;

    // Second history stage so the vote spans the sample cycle and the two before.
    always_ff @(posedge clk_i) begin
        if (reset_i) prev2 <= 1'b1;
        else         prev2 <= prev;
    end

    assign voted_bit = (sync2 & prev) | (sync2 & prev2) | (prev & prev2);
`else
    assign voted_bit = sync2;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversamples rx_i, checks start/parity/stop bits and presents
// each word with a one-cycle rx_v_o pulse. Optional UART_RX_MAJORITY_VOTE_EN
// (in uart_rx_sampler) votes each sample over three cycles; latency unchanged.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clk_per_bit_p = default_clk_per_bit_lp,
    parameter int data_bits_p   = 8,
    parameter int parity_bit_p  = 0,
    parameter int stop_bits_p   = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   rx_i,
    output logic [data_bits_p-1:0] rx_o,
    output logic                   rx_v_o,
    output logic                   parity_err_o,
    output logic                   frame_err_o,
    output logic                   busy_o
);

    localparam int cnt_w  = `SAFE_CLOG2(clk_per_bit_p + 1);
    localparam int dcnt_w = `SAFE_CLOG2(data_bits_p);

    localparam logic [cnt_w-1:0]  half_lp  = cnt_w'(clk_per_bit_p / 2 - 1);
    localparam logic [cnt_w-1:0]  full_lp  = cnt_w'(clk_per_bit_p - 1);
    localparam logic [dcnt_w-1:0] last_d   = dcnt_w'(data_bits_p - 1);
    localparam logic [dcnt_w-1:0] last_s   = dcnt_w'(stop_bits_p - 1);

    rx_state_e              state, state_n;
    logic [cnt_w-1:0]       clk_cnt, clk_cnt_n;
    logic [dcnt_w-1:0]      data_cnt, data_cnt_n;
    logic [data_bits_p-1:0] shift_r, shift_n;
    logic                   par_acc, par_n;
    logic                   perr_r, perr_n;
    logic                   ferr_r, ferr_n;
    logic                   done;
    logic                   rx_s, fall_edge, sample;

    uart_rx_sampler u_sampler (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .rx_i      (rx_i),
        .rx_s      (rx_s),
        .fall_edge (fall_edge),
        .voted_bit (sample)
    );

    assign busy_o = (state != e_idle) && (state != e_reset);

    // Frame state and datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= e_reset;
            clk_cnt  <= '0;
            data_cnt <= '0;
            shift_r  <= '0;
            par_acc  <= 1'b0;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_cnt_n;
            data_cnt <= data_cnt_n;
            shift_r  <= shift_n;
            par_acc  <= par_n;
            perr_r   <= perr_n;
            ferr_r   <= ferr_n;
        end
    end

    // Next-state logic: mid-bit start check, then one sample per full bit period.
    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt + cnt_w'(1);
        data_cnt_n = data_cnt;
        shift_n    = shift_r;
        par_n      = par_acc;
        perr_n     = perr_r;
        ferr_n     = ferr_r;
        done       = 1'b0;
        case (state)
            e_reset: begin
                state_n   = e_idle;
                clk_cnt_n = '0;
            end
            e_idle: begin
                clk_cnt_n  = '0;
                data_cnt_n = '0;
                par_n      = 1'b0;
                perr_n     = 1'b0;
                ferr_n     = 1'b0;
                // fall_edge already implies rx_s low; a line held low never qualifies.
                if (fall_edge && !rx_s) state_n = e_start_bit;
            end
            e_start_bit: begin
                if (clk_cnt == half_lp) begin
                    clk_cnt_n = '0;
                    state_n   = sample ? e_idle : e_data_bits;
                end
            end
            e_data_bits: begin
                if (clk_cnt == full_lp) begin
                    clk_cnt_n         = '0;
                    shift_n[data_cnt] = sample;
                    par_n             = even_parity_step(par_acc, sample);
                    if (data_cnt == last_d) begin
                        data_cnt_n = '0;
                        state_n    = (parity_bit_p != 0) ? e_parity_bit : e_stop_bit;
                    end else begin
                        data_cnt_n = data_cnt + dcnt_w'(1);
                    end
                end
            end
            e_parity_bit: begin
                if (clk_cnt == full_lp) begin
                    clk_cnt_n = '0;
                    perr_n    = even_parity_step(par_acc, sample);
                    state_n   = e_stop_bit;
                end
            end
            e_stop_bit: begin
                if (clk_cnt == full_lp) begin
                    clk_cnt_n = '0;
                    if (!sample) ferr_n = 1'b1;
                    if (data_cnt == last_s) begin
                        // Back to idle at the mid-stop point so a following start edge is seen.
                        done    = 1'b1;
                        state_n = e_idle;
                    end else begin
                        data_cnt_n = data_cnt + dcnt_w'(1);
                    end
                end
            end
            default: state_n = e_idle;
        endcase
    end

    // Output word and status, updated together with the one-cycle valid pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_o         <= '0;
            rx_v_o       <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            rx_v_o <= done;
            if (done) begin
                rx_o         <= shift_n;
                parity_err_o <= perr_n;
                frame_err_o  <= ferr_n;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three instances (no parity / even parity / two stop bits)
// at 16 clocks per bit, a frame-level expectation model and per-cycle compare.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int NI  = 3;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       rx_line [NI];
    logic [7:0] rx_w    [NI];
    logic       v_w     [NI];
    logic       pe_w    [NI];
    logic       fe_w    [NI];
    logic       busy_w  [NI];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    bit rst_q = 1'b1;
    int frame_k = 0;

    // Model: one pending frame per instance plus the values it must be holding.
    bit         pv   [NI];
    int         pcyc [NI];
    logic [7:0] pd   [NI];
    logic       ppe  [NI];
    logic       pfe  [NI];
    logic [7:0] hd   [NI];
    logic       hpe  [NI];
    logic       hfe  [NI];
    int         last_v [NI];

    uart_rx #(.clk_per_bit_p(CPB), .data_bits_p(8), .parity_bit_p(0), .stop_bits_p(1)) u0 (
        .clk_i(clk), .reset_i(reset_i), .rx_i(rx_line[0]), .rx_o(rx_w[0]), .rx_v_o(v_w[0]),
        .parity_err_o(pe_w[0]), .frame_err_o(fe_w[0]), .busy_o(busy_w[0]));
    uart_rx #(.clk_per_bit_p(CPB), .data_bits_p(8), .parity_bit_p(1), .stop_bits_p(1)) u1 (
        .clk_i(clk), .reset_i(reset_i), .rx_i(rx_line[1]), .rx_o(rx_w[1]), .rx_v_o(v_w[1]),
        .parity_err_o(pe_w[1]), .frame_err_o(fe_w[1]), .busy_o(busy_w[1]));
    uart_rx #(.clk_per_bit_p(CPB), .data_bits_p(8), .parity_bit_p(0), .stop_bits_p(2)) u2 (
        .clk_i(clk), .reset_i(reset_i), .rx_i(rx_line[2]), .rx_o(rx_w[2]), .rx_v_o(v_w[2]),
        .parity_err_o(pe_w[2]), .frame_err_o(fe_w[2]), .busy_o(busy_w[2]));

    always #5 clk = ~clk;

    function automatic int par_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int nstop_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[u%0d] cyc=%0d got=%0h expected=%0h", name, i, cyc, act, exp);
    endtask

    always @(posedge clk) begin
        cyc++;
        rst_q = reset_i;
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic due;
            due = 1'b0;
            if (rst_q) begin
                pv[i]  = 1'b0;
                hd[i]  = 8'h00;
                hpe[i] = 1'b0;
                hfe[i] = 1'b0;
            end else begin
                due = pv[i] && (pcyc[i] == cyc);
            end
            chk("rx_v", i, {31'b0, v_w[i]}, {31'b0, due});
            if (due) begin
                hd[i]  = pd[i];
                hpe[i] = ppe[i];
                hfe[i] = pfe[i];
                pv[i]  = 1'b0;
            end
            if (v_w[i] === 1'b1) last_v[i] = cyc;
            chk("rx_o", i, {24'b0, rx_w[i]}, {24'b0, hd[i]});
            chk("parity_err", i, {31'b0, pe_w[i]}, {31'b0, hpe[i]});
            chk("frame_err", i, {31'b0, fe_w[i]}, {31'b0, hfe[i]});
        end
    end

    // Drive one line for n cycles; starts and ends just after a rising edge.
    task automatic hold(input int i, input logic v, input int n);
        rx_line[i] = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < NI; i++) rx_line[i] = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send one frame; spike >= 0 puts a 1-cycle inverted pulse at that data bit's centre.
    task automatic send_frame(input int i, input logic [7:0] d, input logic pb,
                              input logic [1:0] stops, input int spike);
        int k;
        int n;
        logic [7:0] de;
        logic fe;
        k  = cyc;
        n  = 8 + par_of(i) + nstop_of(i);
        de = d;
`ifndef UART_RX_MAJORITY_VOTE_EN
        if (spike >= 0) de[spike] = ~d[spike];
`endif
        fe = 1'b0;
        for (int s = 0; s < nstop_of(i); s++) if (!stops[s]) fe = 1'b1;
        // 2 sync cycles + half bit to the start mid-point + n bit periods + 1 output register.
        pv[i]   = 1'b1;
        pcyc[i] = k + 2 + CPB / 2 + CPB * n + 1;
        pd[i]   = de;
        ppe[i]  = (par_of(i) != 0) ? ((^de) ^ pb) : 1'b0;
        pfe[i]  = fe;
        frame_k = k;
        hold(i, 1'b0, CPB);
        for (int j = 0; j < 8; j++) begin
            if (j == spike) begin
                hold(i, d[j], CPB / 2);
                hold(i, ~d[j], 1);
                hold(i, d[j], CPB / 2 - 1);
            end else begin
                hold(i, d[j], CPB);
            end
        end
        if (par_of(i) != 0) hold(i, pb, CPB);
        for (int s = 0; s < nstop_of(i); s++) hold(i, stops[s], CPB);
    endtask

    initial begin
        int k;
        for (int i = 0; i < NI; i++) begin
            rx_line[i] = 1'b1;
            pv[i] = 1'b0;
            last_v[i] = 0;
        end
        repeat (4) @(posedge clk);
        #1;
        reset_i = 1'b0;
        chk("reset_busy", 0, {31'b0, busy_w[0]}, 32'd0);
        chk("reset_rx_o", 1, {24'b0, rx_w[1]}, 32'd0);
        idle(20);

        // Plain frame, latency pinned by hand: 2 + 8 + 9*16 + 1 = 155 from rx_i.
        send_frame(0, 8'hA5, 1'b0, 2'b11, -1);
        chk("lat_a5", 0, last_v[0] - frame_k, 32'd155);
        chk("data_a5", 0, {24'b0, rx_w[0]}, 32'h0000_00A5);
        idle(20);

        // Even parity: 0x07 has three ones, so parity bit 1 is correct, 0 is an error.
        send_frame(1, 8'h07, 1'b1, 2'b11, -1);
        chk("par_ok", 1, {31'b0, pe_w[1]}, 32'd0);
        chk("lat_par", 1, last_v[1] - frame_k, 32'd171);
        idle(20);
        send_frame(1, 8'h07, 1'b0, 2'b11, -1);
        chk("par_bad", 1, {31'b0, pe_w[1]}, 32'd1);
        chk("par_bad_data", 1, {24'b0, rx_w[1]}, 32'h0000_0007);
        idle(20);

        // Two stop bits: clean, then second stop low.
        send_frame(2, 8'hC3, 1'b0, 2'b11, -1);
        chk("stop2_ok", 2, {31'b0, fe_w[2]}, 32'd0);
        idle(20);
        send_frame(2, 8'h3C, 1'b0, 2'b10, -1);
        chk("stop2_bad", 2, {31'b0, fe_w[2]}, 32'd1);
        chk("stop2_data", 2, {24'b0, rx_w[2]}, 32'h0000_003C);
        idle(20);

        // Break: 40 bit times low gives exactly one all-zero frame with a framing error.
        k = cyc;
        pv[0] = 1'b1; pcyc[0] = k + 155; pd[0] = 8'h00; ppe[0] = 1'b0; pfe[0] = 1'b1;
        hold(0, 1'b0, 40 * CPB);
        hold(0, 1'b1, 32);
        chk("break_cyc", 0, last_v[0] - k, 32'd155);
        chk("break_fe", 0, {31'b0, fe_w[0]}, 32'd1);

        // 3-cycle glitch: start rejected at the mid-bit check.
        k = cyc;
        hold(0, 1'b0, 3);
        hold(0, 1'b1, 2);
        chk("glitch_busy", 0, {31'b0, busy_w[0]}, 32'd1);
        hold(0, 1'b1, 7);
        chk("glitch_idle", 0, {31'b0, busy_w[0]}, 32'd0);
        idle(20);

        // Back-to-back frames, no idle gap.
        send_frame(0, 8'h55, 1'b0, 2'b11, -1);
        send_frame(0, 8'hAA, 1'b0, 2'b11, -1);
        chk("b2b_lat", 0, last_v[0] - frame_k, 32'd155);
        chk("b2b_data", 0, {24'b0, rx_w[0]}, 32'h0000_00AA);
        idle(20);

        // Reset in data bit 4 of 0xFF: frame dropped, outputs cleared.
        hold(0, 1'b0, CPB);
        hold(0, 1'b1, 4 * CPB + 4);
        reset_i = 1'b1;
        hold(0, 1'b1, 2);
        reset_i = 1'b0;
        chk("rst_rx_o", 0, {24'b0, rx_w[0]}, 32'd0);
        chk("rst_busy", 0, {31'b0, busy_w[0]}, 32'd0);
        chk("rst_fe", 0, {31'b0, fe_w[0]}, 32'd0);
        idle(6 * CPB);
        send_frame(0, 8'h3C, 1'b0, 2'b11, -1);
        chk("post_rst", 0, {24'b0, rx_w[0]}, 32'h0000_003C);
        idle(20);

        // Single-cycle spike at the centre of data bit 3 of 0x00.
        send_frame(0, 8'h00, 1'b0, 2'b11, 3);
`ifdef UART_RX_MAJORITY_VOTE_EN
        chk("spike", 0, {24'b0, rx_w[0]}, 32'h0000_0000);
`else
        chk("spike", 0, {24'b0, rx_w[0]}, 32'h0000_0008);
`endif
        idle(40);

        for (int i = 0; i < NI; i++) chk("pending_left", i, {31'b0, pv[i]}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
